// File: rtl/note_sequencer_pkg.sv
// notes_pkg: ROM word field positions, end marker and sequencer state encoding.
package notes_pkg;
  localparam int DUR_MSB = 19;
  localparam int DUR_LSB = 16;
  localparam int DIV_MSB = 15;
  localparam logic [3:0] END_CODE = 4'h0;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_PLAY  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;
endpackage

// File: rtl/note_sequencer_if.sv
// note_sequencer_if: control, ROM and note-generator signals of the note sequencer.
interface note_sequencer_if #(parameter int AW = 6);
  logic          start;
  logic          stop;
  logic          loop;
  logic [AW-1:0] rom_addr;
  logic [19:0]   rom_data;
  logic [15:0]   note;
  logic          playing;
  logic          done;
  modport master (input start, stop, loop, rom_data, output rom_addr, note, playing, done);
  modport slave  (output start, stop, loop, rom_data, input rom_addr, note, playing, done);
endinterface

// File: rtl/note_sequencer_dur_timer.sv
// dur_timer: loadable down-counter that stops at zero and flags it.
module dur_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         zero
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) cnt <= '0;
    else if (load) cnt <= value;
    else if (en && !zero) cnt <= cnt - W'(1);
  assign zero = cnt == '0;
endmodule

// File: rtl/note_sequencer.sv
// note_sequencer: walks the note ROM, drives the note divisor with an articulation gap per entry.
module note_sequencer
  import notes_pkg::*;
#(
  parameter int AW   = 6,
  parameter int TICK = 1200000,
  parameter int GAP  = 12000
) (
  input logic               clk,
  input logic               rstn,
  note_sequencer_if.master  bus
);
  localparam int TW = $clog2(15 * TICK);
  localparam logic [TW-1:0] GAP_LD = TW'(GAP > 0 ? GAP - 1 : 0);
  logic [2:0]    state;
  logic [3:0]    code;
  logic          t_load, t_en, t_zero, adv, last;
  logic [TW-1:0] t_val;
  always_comb begin
    code   = bus.rom_data[DUR_MSB:DUR_LSB];
    last   = &bus.rom_addr;
    t_en   = state == S_PLAY || state == S_GAP;
    adv    = t_zero && (state == S_GAP || (state == S_PLAY && GAP == 0));
    t_load = (state == S_LOAD && code != END_CODE) || (state == S_PLAY && t_zero && GAP != 0);
    t_val  = state == S_LOAD ? TW'(code) * TW'(TICK) - TW'(GAP) - TW'(1) : GAP_LD;
  end
  dur_timer #(.W(TW)) u_timer (
    .clk  (clk),
    .rstn (rstn),
    .load (t_load),
    .en   (t_en),
    .value(t_val),
    .zero (t_zero)
  );
  // stop wins over every transition, including a same-cycle end of song
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state        <= S_IDLE;
      bus.rom_addr <= '0;
      bus.note     <= '0;
      bus.playing  <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (state != S_IDLE && bus.stop) begin
        state       <= S_IDLE;
        bus.note    <= '0;
        bus.playing <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            bus.note <= '0;
            if (bus.start && !bus.stop) begin
              bus.rom_addr <= '0;
              bus.playing  <= 1'b1;
              state        <= S_FETCH;
            end
          end
          S_FETCH: state <= S_LOAD;
          S_LOAD:
            if (code == END_CODE) begin
              if (bus.loop) begin
                bus.rom_addr <= '0;
                state        <= S_FETCH;
              end else begin
                bus.done    <= 1'b1;
                bus.playing <= 1'b0;
                state       <= S_IDLE;
              end
            end else begin
              bus.note <= bus.rom_data[DIV_MSB:0];
              state    <= S_PLAY;
            end
          S_PLAY:
            if (t_zero) begin
              bus.note <= '0;
              state    <= S_GAP;
            end
          S_GAP: ;
          default: state <= S_IDLE;
        endcase
        if (adv) begin
          bus.rom_addr <= bus.rom_addr + 1'b1;
          if (last && !bus.loop) begin
            bus.done    <= 1'b1;
            bus.playing <= 1'b0;
            state       <= S_IDLE;
          end else state <= S_FETCH;
        end
      end
    end
endmodule
